// File: rtl/seven_seg_scan_driver_if.sv
// Bus bundle between the display driver and its client: captured value/strobe in,
// multiplexed segment/digit drive and busy flag out.
interface seven_seg_scan_driver_if;
  logic [7:0] value;
  logic       load;
  logic       dp_in;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [2:0] digit_sel;
  logic       busy;

  modport master (
    output value, load, dp_in,
    input  seg_out, dp_out, digit_sel, busy
  );

  modport slave (
    input  value, load, dp_in,
    output seg_out, dp_out, digit_sel, busy
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed 7-segment driver: two hex digits by default, or three decimal digits
// via a sequential double-dabble converter when SEG_DECIMAL_EN is defined.
module seven_seg_scan_driver #(
  parameter logic [23:0] REFRESH_DIV = 24'd10_000
) (
  input logic clk,
  input logic rst_n,
  seven_seg_scan_driver_if.slave bus
);

`ifdef SEG_DECIMAL_EN
  localparam logic [1:0] LAST_DIGIT = 2'd2;
`else
  localparam logic [1:0] LAST_DIGIT = 2'd1;
`endif

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      4'hF: hex_to_seg = 7'h71;
      default: hex_to_seg = 7'h00;
    endcase
  endfunction

  logic [23:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] disp_q, disp_d;
  logic        dpl_q, dpl_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [2:0]  sel_q, sel_d;
  logic        tc_s;
  logic [3:0]  nib_s;
  logic        blank_s;

`ifdef SEG_DECIMAL_EN
  typedef enum logic {ST_IDLE, ST_CONV} state_t;

  // One add-3-then-shift step over three BCD nibbles.
  function automatic logic [11:0] bcd_step(input logic [11:0] bcd, input logic bit_in);
    logic [11:0] adj;
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
      end else begin
        adj[i*4 +: 4] = adj[i*4 +: 4];
      end
    end
    bcd_step = {adj[10:0], bit_in};
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        dpp_q, dpp_d;
  logic [11:0] step_s;

  assign step_s  = bcd_step(bcd_q, bin_q[7]);
  assign bus.busy = (state_q == ST_CONV);
`else
  assign bus.busy = 1'b0;
`endif

  assign tc_s = (presc_q == REFRESH_DIV - 24'd1);

  // Select the nibble and blanking state of the digit about to be shown.
  always_comb begin
    nib_s   = 4'h0;
    blank_s = 1'b0;
    case (idx_q)
      2'd0: begin nib_s = disp_q[3:0];  blank_s = 1'b0;                  end
      2'd1: begin nib_s = disp_q[7:4];  blank_s = (disp_q[11:4] == 8'h00); end
      2'd2: begin nib_s = disp_q[11:8]; blank_s = (disp_q[11:8] == 4'h0);  end
      default: begin nib_s = 4'h0; blank_s = 1'b1; end
    endcase
  end

  // Next-state logic for scan, display register and converter.
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    dpl_d   = dpl_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    sel_d   = sel_q;
`ifdef SEG_DECIMAL_EN
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dpp_d   = dpp_q;
`endif
    // Enable and segments change together on the terminal-count edge.
    if (tc_s) begin
      presc_d = 24'd0;
      sel_d   = 3'b001 << idx_q;
      seg_d   = blank_s ? 7'h00 : hex_to_seg(nib_s);
      dp_d    = (idx_q == 2'd0) && dpl_q;
      idx_d   = (idx_q == LAST_DIGIT) ? 2'd0 : idx_q + 2'd1;
    end else begin
      presc_d = presc_q + 24'd1;
    end
`ifdef SEG_DECIMAL_EN
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          state_d = ST_CONV;
          bin_d   = bus.value;
          bcd_d   = 12'h000;
          cnt_d   = 3'd0;
          dpp_d   = bus.dp_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        bcd_d = step_s;
        bin_d = {bin_q[6:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          disp_d  = step_s;
          dpl_d   = dpp_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CONV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    if (bus.load) begin
      disp_d = {4'h0, bus.value};
      dpl_d  = bus.dp_in;
    end else begin
      disp_d = disp_q;
    end
`endif
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= 24'd0;
      idx_q   <= 2'd0;
      disp_q  <= 12'h000;
      dpl_q   <= 1'b0;
      seg_q   <= 7'h00;
      dp_q    <= 1'b0;
      sel_q   <= 3'b000;
`ifdef SEG_DECIMAL_EN
      state_q <= ST_IDLE;
      bin_q   <= 8'h00;
      bcd_q   <= 12'h000;
      cnt_q   <= 3'd0;
      dpp_q   <= 1'b0;
`endif
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      dpl_q   <= dpl_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      sel_q   <= sel_d;
`ifdef SEG_DECIMAL_EN
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dpp_q   <= dpp_d;
`endif
    end
  end

  assign bus.seg_out   = seg_q;
  assign bus.dp_out    = dp_q;
  assign bus.digit_sel = sel_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with REFRESH_DIV=4; covers hex mode by
// default and decimal mode when SEG_DECIMAL_EN is defined.
module tb_seven_seg_scan_driver;

  typedef struct {
    logic [7:0] value;
    logic       dp;
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s2;
    logic       d0;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seven_seg_scan_driver_if bus();

  seven_seg_scan_driver #(.REFRESH_DIV(24'd4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] v, input logic dp);
    @(negedge clk);
    bus.value = v;
    bus.dp_in = dp;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  // Wait for a fresh advance onto digit t (leave t first if already there).
  task automatic wait_sel(input logic [2:0] t);
    int n;
    n = 0;
    while (bus.digit_sel == t && n < 60) begin @(negedge clk); n++; end
    while (bus.digit_sel != t && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL wait_sel actual=%0b required=%0b", bus.digit_sel, t);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
  endtask

`ifdef SEG_DECIMAL_EN
  vec_t tbl[4];
`else
  vec_t tbl[8];
`endif

  initial begin
    int n;
    checks = 0;
    errors = 0;
`ifdef SEG_DECIMAL_EN
    tbl[0] = '{8'd7,   1'b0, 7'h07, 7'h00, 7'h00, 1'b0};
    tbl[1] = '{8'd100, 1'b0, 7'h3F, 7'h3F, 7'h06, 1'b0};
    tbl[2] = '{8'd255, 1'b0, 7'h6D, 7'h6D, 7'h5B, 1'b0};
    tbl[3] = '{8'd10,  1'b1, 7'h3F, 7'h06, 7'h00, 1'b1};
`else
    tbl[0] = '{8'hA7, 1'b0, 7'h07, 7'h77, 7'h00, 1'b0};
    tbl[1] = '{8'h05, 1'b0, 7'h6D, 7'h00, 7'h00, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 7'h3F, 7'h00, 7'h00, 1'b0};
    tbl[3] = '{8'h3C, 1'b1, 7'h39, 7'h4F, 7'h00, 1'b1};
    tbl[4] = '{8'hFF, 1'b0, 7'h71, 7'h71, 7'h00, 1'b0};
    tbl[5] = '{8'h10, 1'b0, 7'h3F, 7'h06, 7'h00, 1'b0};
    tbl[6] = '{8'h08, 1'b1, 7'h7F, 7'h00, 7'h00, 1'b1};
    tbl[7] = '{8'hE2, 1'b0, 7'h5B, 7'h79, 7'h00, 1'b0};
`endif
    bus.value = 8'h00;
    bus.load  = 1'b0;
    bus.dp_in = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a scan.
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_seg", {25'd0, bus.seg_out}, 32'h00);
    chk("rst_dp", {31'd0, bus.dp_out}, 32'h0);
    chk("rst_sel", {29'd0, bus.digit_sel}, 32'h0);
    chk("rst_busy", {31'd0, bus.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel_hold", {29'd0, bus.digit_sel}, 32'h0);
    @(negedge clk);
    chk("rst_first_sel", {29'd0, bus.digit_sel}, 32'h1);
    chk("rst_first_seg", {25'd0, bus.seg_out}, 32'h3F);
    chk("rst_first_dp", {31'd0, bus.dp_out}, 32'h0);

`ifndef SEG_DECIMAL_EN
    // Table of hex loads: digit 0 then digit 1 of each value.
    for (int i = 0; i < 8; i++) begin
      do_load(tbl[i].value, tbl[i].dp);
      wait_sel(3'b001);
      chk("hex_seg0", {25'd0, bus.seg_out}, {25'd0, tbl[i].s0});
      chk("hex_dp0", {31'd0, bus.dp_out}, {31'd0, tbl[i].d0});
      wait_sel(3'b010);
      chk("hex_seg1", {25'd0, bus.seg_out}, {25'd0, tbl[i].s1});
      chk("hex_dp1", {31'd0, bus.dp_out}, 32'h0);
      chk("hex_busy", {31'd0, bus.busy}, 32'h0);
    end

    // Digit period and sequence 001,010,001.
    do_load(8'hA7, 1'b0);
    wait_sel(3'b001);
    n = 0;
    while (bus.digit_sel == 3'b001 && n < 20) begin n++; @(negedge clk); end
    chk("hold_d0", n, 32'd4);
    chk("seq_d1", {29'd0, bus.digit_sel}, 32'h2);
    n = 0;
    while (bus.digit_sel == 3'b010 && n < 20) begin n++; @(negedge clk); end
    chk("hold_d1", n, 32'd4);
    chk("seq_d0", {29'd0, bus.digit_sel}, 32'h1);

    // Load coinciding with a terminal count uses the old value for that advance.
    do_load(8'h3C, 1'b1);
    wait_sel(3'b001);
    n = 0;
    while (bus.digit_sel == 3'b001 && n < 20) begin n++; @(negedge clk); end
    repeat (3) @(negedge clk);
    bus.value = 8'h21;
    bus.dp_in = 1'b0;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    chk("tc_old_sel", {29'd0, bus.digit_sel}, 32'h1);
    chk("tc_old_seg", {25'd0, bus.seg_out}, 32'h39);
    chk("tc_old_dp", {31'd0, bus.dp_out}, 32'h1);
    repeat (4) @(negedge clk);
    chk("tc_new_sel1", {29'd0, bus.digit_sel}, 32'h2);
    chk("tc_new_seg1", {25'd0, bus.seg_out}, 32'h5B);
    repeat (4) @(negedge clk);
    chk("tc_new_seg0", {25'd0, bus.seg_out}, 32'h06);
    chk("tc_new_dp0", {31'd0, bus.dp_out}, 32'h0);
`else
    // Table of decimal loads: busy length then all three digits.
    for (int i = 0; i < 4; i++) begin
      do_load(tbl[i].value, tbl[i].dp);
      wait_idle(n);
      chk("dec_busy_len", n, 32'd8);
      wait_sel(3'b001);
      chk("dec_seg0", {25'd0, bus.seg_out}, {25'd0, tbl[i].s0});
      chk("dec_dp0", {31'd0, bus.dp_out}, {31'd0, tbl[i].d0});
      wait_sel(3'b010);
      chk("dec_seg1", {25'd0, bus.seg_out}, {25'd0, tbl[i].s1});
      wait_sel(3'b100);
      chk("dec_seg2", {25'd0, bus.seg_out}, {25'd0, tbl[i].s2});
      chk("dec_dp2", {31'd0, bus.dp_out}, 32'h0);
    end

    // Second load while busy is ignored.
    do_load(8'd255, 1'b0);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      bus.value = 8'd9;
      bus.load  = (n == 3);
      n++;
      @(negedge clk);
    end
    bus.load = 1'b0;
    chk("ign_busy_len", n, 32'd8);
    repeat (3) @(negedge clk);
    chk("ign_busy_low", {31'd0, bus.busy}, 32'h0);
    wait_sel(3'b001);
    chk("ign_seg0", {25'd0, bus.seg_out}, 32'h6D);
    wait_sel(3'b010);
    chk("ign_seg1", {25'd0, bus.seg_out}, 32'h6D);
    wait_sel(3'b100);
    chk("ign_seg2", {25'd0, bus.seg_out}, 32'h5B);

    // Reset on the fourth busy cycle aborts the conversion.
    do_load(8'd200, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", {31'd0, bus.busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sel(3'b001);
    chk("abort_seg0", {25'd0, bus.seg_out}, 32'h3F);
    chk("abort_busy_post", {31'd0, bus.busy}, 32'h0);
    wait_sel(3'b010);
    chk("abort_seg1", {25'd0, bus.seg_out}, 32'h00);
    wait_sel(3'b100);
    chk("abort_seg2", {25'd0, bus.seg_out}, 32'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
